// File: rtl/mac_row_driver.sv
// mac_row_driver
// Drives the west edge of a systolic MAC array: a kernel-load phase of col
// weight beats, a one-cycle gap, an execute phase of num_vec activation beats,
// then a drain phase that flushes the per-row skew pipeline before done.
// Optional feature macro: MAC_ROW_DRIVER_SKEW_EN
//   defined   -> row r is delayed r extra cycles behind row 0, DRAIN lasts row cycles
//   undefined -> every row sees the same beat one cycle after issue, DRAIN lasts 1 cycle
module mac_row_driver #(
    parameter int bw  = 4,
    parameter int row = 8,
    parameter int col = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          num_vec,
    input  logic [row*bw-1:0]   w_data,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [row*bw-1:0]   x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic [row*bw-1:0]   in_w,
    output logic [2*row-1:0]    inst_w,
    output logic                busy,
    output logic                done
);

`ifdef MAC_ROW_DRIVER_SKEW_EN
    localparam int SKEW_EN = 1;
`else
    localparam int SKEW_EN = 0;
`endif

    localparam int          DRAIN_CYC  = (SKEW_EN != 0) ? row : 1;
    localparam logic [7:0]  COL_LAST   = 8'(col - 1);
    localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYC - 1);

    localparam logic [1:0]  INST_NOP   = 2'b00;
    localparam logic [1:0]  INST_LOAD  = 2'b01;
    localparam logic [1:0]  INST_EXEC  = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GAP   = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [7:0]          cnt_r, cnt_s;
    logic [7:0]          nv_r, nv_s;
    logic [row*bw-1:0]   beat_data_s;
    logic [1:0]          beat_inst_s;
    logic                w_ready_r, x_ready_r, busy_r, done_r;

    // State, beat counter, latched vector count and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            nv_r      <= 8'd0;
            w_ready_r <= 1'b0;
            x_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            nv_r      <= nv_s;
            w_ready_r <= (state_s == LOAD);
            x_ready_r <= (state_s == EXEC);
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_s == DONE);
        end
    end

    // Next-state logic and the beat presented to the first pipeline stage
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        nv_s        = nv_r;
        beat_data_s = '0;
        beat_inst_s = INST_NOP;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD;
                    nv_s    = num_vec;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (w_valid && w_ready_r) begin
                    beat_inst_s = INST_LOAD;
                    beat_data_s = w_data;
                    if (cnt_r == COL_LAST) begin
                        state_s = GAP;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s   = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            GAP: begin
                cnt_s = 8'd0;
                if (nv_r != 8'd0) begin
                    state_s = EXEC;
                end else begin
                    state_s = DRAIN;
                end
            end
            EXEC: begin
                if (x_valid && x_ready_r) begin
                    beat_inst_s = INST_EXEC;
                    beat_data_s = x_data;
                    if (cnt_r == (nv_r - 8'd1)) begin
                        state_s = DRAIN;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s   = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_s = DONE;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Per-row skew chain: row r holds depth+1 registers, the last drives the array
    for (genvar r = 0; r < row; r++) begin : g_row
        localparam int DEPTH = (SKEW_EN != 0) ? r : 0;

        logic [bw-1:0] stage_data_r [0:DEPTH];
        logic [1:0]    stage_inst_r [0:DEPTH];

        // Capture this row's slice of the issued beat and shift it toward the array
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= DEPTH; k++) begin
                    stage_data_r[k] <= '0;
                    stage_inst_r[k] <= INST_NOP;
                end
            end else begin
                stage_data_r[0] <= beat_data_s[r*bw +: bw];
                stage_inst_r[0] <= beat_inst_s;
                for (int k = 1; k <= DEPTH; k++) begin
                    stage_data_r[k] <= stage_data_r[k-1];
                    stage_inst_r[k] <= stage_inst_r[k-1];
                end
            end
        end

        assign in_w[r*bw +: bw]  = stage_data_r[DEPTH];
        assign inst_w[2*r +: 2]  = stage_inst_r[DEPTH];
    end

    assign w_ready = w_ready_r;
    assign x_ready = x_ready_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule
